// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage register: FSM state encoding and the
// control value that marks a bubble.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_BUSY,
      ST_FULL
   } state_t;

   // Replicated to CTRL_W bits wherever a bubble is inserted
   localparam logic CTRL_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage entry (valid + payload + control) of a pipeline stage.
// Clear kills the entry with a zero-control bubble while the payload keeps its last value.
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CTRL_W-1:0] load_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= {CTRL_W{CTRL_BUBBLE}};
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= {CTRL_W{CTRL_BUBBLE}};
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         ctrl  <= load_ctrl;
      end
   end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush, an
// optional skid entry for a registered in_ready, and a saturating stall counter.
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   state_t next_state;

   logic              in_fire;
   logic              main_load;
   logic              main_clear;
   logic              skid_load;
   logic              skid_clear;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] main_src_data;
   logic [CTRL_W-1:0] main_src_ctrl;

   assign in_fire = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // A flush overrides the handshake; the downstream side of a flush cycle
   // still completes because main is simply dropped afterwards.
   always_comb begin
      next_state = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         next_state = ST_EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  next_state = ST_BUSY;
                  main_load  = 1'b1;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_ready) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  next_state = ST_FULL;
                  skid_load  = 1'b1;
               end else if (out_ready) begin
                  next_state = ST_EMPTY;
                  main_clear = 1'b1;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  next_state = ST_BUSY;
                  main_load  = 1'b1;
                  skid_clear = 1'b1;
               end
            end
            default: begin
               next_state = ST_EMPTY;
            end
         endcase
      end
   end

   // Skid is only occupied in FULL, so its valid bit selects the refill source
   assign main_src_data = skid_valid ? skid_data : in_data;
   assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk       (clk),
      .reset     (reset),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (main_src_data),
      .load_ctrl (main_src_ctrl),
      .valid     (out_valid),
      .data      (out_data),
      .ctrl      (out_ctrl)
   );

   generate
      if (SKID == 1) begin : g_skid
         logic ready_q;

         pipe_entry_reg #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
         ) u_skid (
            .clk       (clk),
            .reset     (reset),
            .load      (skid_load),
            .clear     (skid_clear),
            .load_data (in_data),
            .load_ctrl (in_ctrl),
            .valid     (skid_valid),
            .data      (skid_data),
            .ctrl      (skid_ctrl)
         );

         // Resets high so the stage accepts in the very first cycle after reset
         always_ff @(posedge clk) begin
            if (reset) begin
               ready_q <= 1'b1;
            end else begin
               ready_q <= (next_state != ST_FULL);
            end
         end

         assign in_ready = ready_q && !flush && !reset;
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_data  = '0;
         assign skid_ctrl  = '0;
         assign in_ready   = (!out_valid || out_ready) && !flush && !reset;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: a skid instance (CNT_W=16), a skid
// instance with a 4-bit counter sharing its inputs, and a single-entry instance.
module tb_pipe_stage_skid_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;

   logic        a_flush, a_in_valid, a_out_ready;
   logic [31:0] a_in_data;
   logic [4:0]  a_in_ctrl;
   logic        a_in_ready, a_out_valid;
   logic [31:0] a_out_data;
   logic [4:0]  a_out_ctrl;
   logic [15:0] a_stall_cnt;

   logic        c_in_ready, c_out_valid;
   logic [31:0] c_out_data;
   logic [4:0]  c_out_ctrl;
   logic [3:0]  c_stall_cnt;

   logic        b_flush, b_in_valid, b_out_ready;
   logic [31:0] b_in_data;
   logic [4:0]  b_in_ctrl;
   logic        b_in_ready, b_out_valid;
   logic [31:0] b_out_data;
   logic [4:0]  b_out_ctrl;
   logic [15:0] b_stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(5), .SKID(1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
      .stall_cnt(a_stall_cnt)
   );

   pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(5), .SKID(1), .CNT_W(4)) dut_cnt4 (
      .clk(clk), .reset(reset), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(c_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
      .out_valid(c_out_valid), .out_ready(a_out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
      .stall_cnt(c_stall_cnt)
   );

   pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(5), .SKID(0), .CNT_W(16)) dut_noskid (
      .clk(clk), .reset(reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
      .stall_cnt(b_stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Control bundle of every vector is the low five bits of its payload
   task automatic drive_a(input logic v, input logic [31:0] d);
      a_in_valid = v;
      a_in_data  = d;
      a_in_ctrl  = d[4:0];
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", a_in_ready); end
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", a_out_valid); end
      checks++; if (a_out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", a_out_data); end
      checks++; if (a_out_ctrl !== 5'h0) begin errors++; $display("[TB] FAIL reset_out_ctrl: got %h expected 0", a_out_ctrl); end
      checks++; if (a_stall_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_stall: got %0d expected 0", a_stall_cnt); end
      reset = 1'b0;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", a_in_ready); end
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready_noskid: got %b expected 1", b_in_ready); end
   endtask

   task automatic test_stream();
      a_out_ready = 1'b1;
      drive_a(1'b1, 32'h11);
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h11 || a_out_ctrl !== 5'h11) begin errors++; $display("[TB] FAIL stream_0: got v=%b d=%h c=%h expected v=1 d=11 c=11", a_out_valid, a_out_data, a_out_ctrl); end
      drive_a(1'b1, 32'h22);
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h22 || a_out_ctrl !== 5'h02) begin errors++; $display("[TB] FAIL stream_1: got v=%b d=%h c=%h expected v=1 d=22 c=02", a_out_valid, a_out_data, a_out_ctrl); end
      drive_a(1'b1, 32'h33);
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h33 || a_out_ctrl !== 5'h13) begin errors++; $display("[TB] FAIL stream_2: got v=%b d=%h c=%h expected v=1 d=33 c=13", a_out_valid, a_out_data, a_out_ctrl); end
      a_in_valid = 1'b0;
      a_in_data  = 'x;
      a_in_ctrl  = 'x;
      tick();
      checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 5'h0 || a_out_data !== 32'h33) begin errors++; $display("[TB] FAIL stream_drain: got v=%b d=%h c=%h expected v=0 d=33 c=00", a_out_valid, a_out_data, a_out_ctrl); end
      checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stream_stall: got %0d expected 0", a_stall_cnt); end
   endtask

   task automatic test_skid();
      a_out_ready = 1'b0;
      drive_a(1'b1, 32'hA);
      tick();
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_busy_ready: got %b expected 1", a_in_ready); end
      drive_a(1'b1, 32'hB);
      tick();
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_full_ready: got %b expected 0", a_in_ready); end
      checks++; if (a_out_data !== 32'hA) begin errors++; $display("[TB] FAIL skid_full_head: got %h expected 0000000a", a_out_data); end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      #1;
      checks++; if (a_stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL skid_stall: got %0d expected 1", a_stall_cnt); end
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB || a_out_ctrl !== 5'h0B) begin errors++; $display("[TB] FAIL skid_second: got v=%b d=%h c=%h expected v=1 d=b c=0b", a_out_valid, a_out_data, a_out_ctrl); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_reopen: got %b expected 1", a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 1'b0 || a_stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL skid_end: got v=%b stall=%0d expected v=0 stall=1", a_out_valid, a_stall_cnt); end
   endtask

   task automatic test_flush();
      a_out_ready = 1'b0;
      drive_a(1'b1, 32'hA);
      tick();
      drive_a(1'b1, 32'hB);
      tick();
      drive_a(1'b1, 32'hD);
      a_flush = 1'b1;
      #1;
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 0", a_in_ready); end
      tick();
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      #1;
      checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 5'h0) begin errors++; $display("[TB] FAIL flush_bubble: got v=%b c=%h expected v=0 c=00", a_out_valid, a_out_ctrl); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty_ready: got %b expected 1", a_in_ready); end
      checks++; if (a_stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL flush_stall: got %0d expected 3", a_stall_cnt); end
      a_out_ready = 1'b1;
      drive_a(1'b1, 32'hC);
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hC || a_out_ctrl !== 5'h0C) begin errors++; $display("[TB] FAIL flush_next: got v=%b d=%h c=%h expected v=1 d=c c=0c", a_out_valid, a_out_data, a_out_ctrl); end
      a_in_valid = 1'b0;
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_alone: got v=%b d=%h expected v=0", a_out_valid, a_out_data); end
   endtask

   task automatic test_single();
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in_data   = 32'h44;
      b_in_ctrl   = 5'h04;
      #1;
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_empty_ready: got %b expected 1", b_in_ready); end
      tick();
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h44) begin errors++; $display("[TB] FAIL single_load: got v=%b d=%h expected v=1 d=44", b_out_valid, b_out_data); end
      checks++; if (b_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_stall_ready: got %b expected 0", b_in_ready); end
      b_out_ready = 1'b1;
      b_in_data   = 32'h55;
      b_in_ctrl   = 5'h15;
      #1;
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_comb_ready: got %b expected 1", b_in_ready); end
      tick();
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h55 || b_out_ctrl !== 5'h15) begin errors++; $display("[TB] FAIL single_replace: got v=%b d=%h c=%h expected v=1 d=55 c=15", b_out_valid, b_out_data, b_out_ctrl); end
      b_flush = 1'b1;
      #1;
      checks++; if (b_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_flush_ready: got %b expected 0", b_in_ready); end
      b_flush    = 1'b0;
      b_in_valid = 1'b0;
      tick();
      checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 5'h0 || b_stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL single_drain: got v=%b c=%h stall=%0d expected v=0 c=00 stall=0", b_out_valid, b_out_ctrl, b_stall_cnt); end
   endtask

   task automatic test_saturate();
      a_out_ready = 1'b0;
      drive_a(1'b1, 32'h66);
      tick();
      a_in_valid = 1'b0;
      repeat (20) tick();
      checks++; if (c_stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_cnt4: got %0d expected 15", c_stall_cnt); end
      checks++; if (a_stall_cnt !== 16'd23) begin errors++; $display("[TB] FAIL sat_cnt16: got %0d expected 23", a_stall_cnt); end
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      #1;
      checks++; if (c_stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_after_flush: got %0d expected 15", c_stall_cnt); end
      checks++; if (a_stall_cnt !== 16'd24 || a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sat_flush16: got stall=%0d v=%b expected stall=24 v=0", a_stall_cnt, a_out_valid); end
      reset = 1'b1;
      tick();
      checks++; if (c_stall_cnt !== 4'd0 || a_stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL sat_reset: got c=%0d a=%0d expected 0 0", c_stall_cnt, a_stall_cnt); end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset_full();
      a_out_ready = 1'b0;
      drive_a(1'b1, 32'h77);
      tick();
      drive_a(1'b1, 32'h88);
      tick();
      checks++; if (a_in_ready !== 1'b0 || a_stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rf_full: got rdy=%b stall=%0d expected rdy=0 stall=1", a_in_ready, a_stall_cnt); end
      a_in_valid = 1'b0;
      reset      = 1'b1;
      tick();
      checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_ctrl !== 5'h0 || a_stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rf_zero: got v=%b d=%h c=%h stall=%0d expected all zero", a_out_valid, a_out_data, a_out_ctrl, a_stall_cnt); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rf_ready_in_reset: got %b expected 0", a_in_ready); end
      reset = 1'b0;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rf_ready_after: got %b expected 1", a_in_ready); end
      a_out_ready = 1'b1;
      drive_a(1'b1, 32'h99);
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h99 || a_out_ctrl !== 5'h19) begin errors++; $display("[TB] FAIL rf_push: got v=%b d=%h c=%h expected v=1 d=99 c=19", a_out_valid, a_out_data, a_out_ctrl); end
      a_in_valid = 1'b0;
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_skid_cleared: got v=%b d=%h expected v=0", a_out_valid, a_out_data); end
   endtask

   initial begin
      reset       = 1'b1;
      a_flush     = 1'b0;
      a_out_ready = 1'b0;
      drive_a(1'b0, 32'h0);
      b_flush     = 1'b0;
      b_in_valid  = 1'b0;
      b_in_data   = 32'h0;
      b_in_ctrl   = 5'h0;
      b_out_ready = 1'b0;
      test_reset();
      test_stream();
      test_skid();
      test_flush();
      test_single();
      test_saturate();
      test_reset_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
